// File: rtl/ps2_packet_assembler.sv
// Frames a PS/2 byte stream into BYTES_PER_PKT-byte packets using a sync check on byte 0,
// with an inter-byte timeout and a single-slot valid/ready output that drops on overflow.
module ps2_packet_assembler #(
  parameter int unsigned          BYTES_PER_PKT = 3,
  parameter int unsigned          BYTE_W        = 8,
  parameter logic [BYTE_W-1:0]    SYNC_MASK     = 8'h08,
  parameter logic [BYTE_W-1:0]    SYNC_VAL      = 8'h08,
  parameter int unsigned          TIMEOUT       = 1024,
  parameter int unsigned          CNT_W         = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [BYTE_W-1:0]                 in_data,
  input  logic                              in_valid,
  output logic [BYTES_PER_PKT*BYTE_W-1:0]   out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              sync_err,
  output logic [CNT_W-1:0]                  drop_count
);

  localparam int unsigned PKT_W = BYTES_PER_PKT * BYTE_W;
  localparam int unsigned IDX_W = (BYTES_PER_PKT > 1) ? $clog2(BYTES_PER_PKT) : 1;
  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_PKT - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [TO_W-1:0]   idle_cnt;
  logic [PKT_W-1:0]  pkt;
  logic [PKT_W-1:0]  next_pkt;

  logic sync_ok;
  logic accept_first;
  logic reject;
  logic store;
  logic complete;
  logic timeout_hit;
  logic slot_free;

  always_comb begin
    sync_ok      = (in_data & SYNC_MASK) == SYNC_VAL;
    accept_first = (state == HUNT) && in_valid && sync_ok;
    reject       = (state == HUNT) && in_valid && !sync_ok;
    store        = accept_first || ((state == COLLECT) && in_valid);
    // idx is 0 in HUNT, so a single-byte packet completes on the sync byte itself
    complete     = store && (idx == LAST_IDX);
    timeout_hit  = (TIMEOUT != 0) && (state == COLLECT) && !in_valid && (idle_cnt == TO_LAST);
    slot_free    = !out_valid || out_ready;
  end

  // Packet as it will look once the current byte lands at position idx (byte 0 in the MSBs)
  always_comb begin
    next_pkt = pkt;
    for (int unsigned k = 0; k < BYTES_PER_PKT; k++) begin
      if (idx == IDX_W'(k)) begin
        next_pkt[(BYTES_PER_PKT-k)*BYTE_W-1 -: BYTE_W] = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= HUNT;
      idx        <= '0;
      idle_cnt   <= '0;
      pkt        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      sync_err   <= 1'b0;
      drop_count <= '0;
    end else begin
      sync_err <= reject || timeout_hit;

      if (store) begin
        pkt <= next_pkt;
      end

      case (state)
        HUNT: begin
          if (accept_first && !complete) begin
            state    <= COLLECT;
            idx      <= IDX_W'(1);
            idle_cnt <= '0;
          end
        end
        COLLECT: begin
          if (in_valid) begin
            idle_cnt <= '0;
            if (complete) begin
              state <= HUNT;
              idx   <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else if (timeout_hit) begin
            state    <= HUNT;
            idx      <= '0;
            idle_cnt <= '0;
          end else if (TIMEOUT != 0) begin
            idle_cnt <= idle_cnt + TO_W'(1);
          end
        end
        default: begin
          state <= HUNT;
          idx   <= '0;
        end
      endcase

      // A completion in the same cycle as an acceptance refills the slot without a bubble
      if (complete) begin
        if (slot_free) begin
          out_data  <= next_pkt;
          out_valid <= 1'b1;
        end else if (drop_count != CNT_MAX) begin
          drop_count <= drop_count + CNT_W'(1);
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_packet_assembler.sv
// Directed bench: a per-cycle vector table on the default instance, plus hand sequences
// for timeout, drop saturation, mid-packet reset and single-byte packets.
module tb_ps2_packet_assembler;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        out_ready;

  logic [23:0] od0, od1;
  logic [7:0]  od2;
  logic        ov0, ov1, ov2;
  logic        se0, se1, se2;
  logic [7:0]  dc0, dc2;
  logic [1:0]  dc1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_packet_assembler u0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .out_data(od0), .out_valid(ov0), .out_ready(out_ready),
    .sync_err(se0), .drop_count(dc0)
  );

  ps2_packet_assembler #(.TIMEOUT(16), .CNT_W(2)) u1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
    .sync_err(se1), .drop_count(dc1)
  );

  ps2_packet_assembler #(.BYTES_PER_PKT(1)) u2 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .out_data(od2), .out_valid(ov2), .out_ready(out_ready),
    .sync_err(se2), .drop_count(dc2)
  );

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        r;
    logic        ev;
    logic [23:0] ed;
    logic        ee;
    logic [7:0]  edc;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Inputs for one cycle; outputs are sampled 1 time unit after the edge that consumed them
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(1'b0, 8'h00, 1'b1);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    //               v  d      r  ev  ed           ee  edc
    tbl[0]  = '{1'b1, 8'h08, 1'b1, 1'b0, 24'h000000, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 8'h12, 1'b1, 1'b0, 24'h000000, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 8'h34, 1'b1, 1'b1, 24'h081234, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 24'h081234, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 24'h081234, 1'b1, 8'd0};
    tbl[5]  = '{1'b1, 8'h08, 1'b1, 1'b0, 24'h081234, 1'b0, 8'd0};
    tbl[6]  = '{1'b1, 8'hAA, 1'b1, 1'b0, 24'h081234, 1'b0, 8'd0};
    tbl[7]  = '{1'b1, 8'hBB, 1'b1, 1'b1, 24'h08AABB, 1'b0, 8'd0};
    tbl[8]  = '{1'b1, 8'hF7, 1'b1, 1'b0, 24'h08AABB, 1'b1, 8'd0};
    tbl[9]  = '{1'b1, 8'h0F, 1'b1, 1'b0, 24'h08AABB, 1'b0, 8'd0};
    tbl[10] = '{1'b1, 8'hFF, 1'b1, 1'b0, 24'h08AABB, 1'b0, 8'd0};
    tbl[11] = '{1'b1, 8'h00, 1'b1, 1'b1, 24'h0FFF00, 1'b0, 8'd0};
    tbl[12] = '{1'b1, 8'h08, 1'b0, 1'b1, 24'h0FFF00, 1'b0, 8'd0};
    tbl[13] = '{1'b1, 8'h01, 1'b0, 1'b1, 24'h0FFF00, 1'b0, 8'd0};
    tbl[14] = '{1'b1, 8'h02, 1'b0, 1'b1, 24'h0FFF00, 1'b0, 8'd1};
    tbl[15] = '{1'b1, 8'h08, 1'b0, 1'b1, 24'h0FFF00, 1'b0, 8'd1};
    tbl[16] = '{1'b1, 8'h05, 1'b0, 1'b1, 24'h0FFF00, 1'b0, 8'd1};
    tbl[17] = '{1'b1, 8'h06, 1'b1, 1'b1, 24'h080506, 1'b0, 8'd1};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 24'h080506, 1'b0, 8'd1};
    tbl[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 24'h080506, 1'b0, 8'd1};

    // Reset state
    step(1'b0, 8'h00, 1'b1);
    chk("rst_valid", 64'(ov0), 64'(1'b0));
    chk("rst_data",  64'(od0), 64'(24'h0));
    chk("rst_err",   64'(se0), 64'(1'b0));
    chk("rst_drop",  64'(dc0), 64'(8'd0));
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("row%0d_valid", i), 64'(ov0), 64'(tbl[i].ev));
      chk($sformatf("row%0d_data", i),  64'(od0), 64'(tbl[i].ed));
      chk($sformatf("row%0d_err", i),   64'(se0), 64'(tbl[i].ee));
      chk($sformatf("row%0d_drop", i),  64'(dc0), 64'(tbl[i].edc));
    end

    // Timeout after 16 idle cycles mid-packet
    do_reset();
    step(1'b1, 8'h08, 1'b1);
    step(1'b1, 8'h11, 1'b1);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk($sformatf("to_idle%0d_err", i), 64'(se1), 64'(1'b0));
    end
    step(1'b0, 8'h00, 1'b1);
    chk("to_err_pulse", 64'(se1), 64'(1'b1));
    step(1'b0, 8'h00, 1'b1);
    chk("to_err_clear", 64'(se1), 64'(1'b0));
    step(1'b1, 8'h09, 1'b1);
    step(1'b1, 8'h22, 1'b1);
    step(1'b1, 8'h33, 1'b1);
    chk("to_pkt_valid", 64'(ov1), 64'(1'b1));
    chk("to_pkt_data",  64'(od1), 64'(24'h092233));

    // A byte arriving on the cycle the timeout would fire keeps the packet alive
    step(1'b1, 8'h08, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h44, 1'b1);
    chk("to_edge_err", 64'(se1), 64'(1'b0));
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h55, 1'b1);
    chk("to_edge_err2",  64'(se1), 64'(1'b0));
    chk("to_edge_valid", 64'(ov1), 64'(1'b1));
    chk("to_edge_data",  64'(od1), 64'(24'h084455));

    // Six packets with the consumer stalled: first held, five dropped
    do_reset();
    for (int p = 0; p < 6; p++) begin
      step(1'b1, 8'h08, 1'b0);
      step(1'b1, 8'(8'h10 + p), 1'b0);
      step(1'b1, 8'(8'h20 + p), 1'b0);
    end
    chk("sat_drop_w2", 64'(dc1), 64'(2'd3));
    chk("sat_drop_w8", 64'(dc0), 64'(8'd5));
    chk("sat_held",    64'(od1), 64'(24'h081020));
    chk("sat_valid",   64'(ov1), 64'(1'b1));

    // Reset in the middle of a packet
    step(1'b1, 8'h08, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    reset = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    chk("mid_rst_valid", 64'(ov1), 64'(1'b0));
    chk("mid_rst_data",  64'(od1), 64'(24'h0));
    chk("mid_rst_drop",  64'(dc1), 64'(2'd0));
    chk("mid_rst_err",   64'(se1), 64'(1'b0));
    reset = 1'b1;
    step(1'b1, 8'h02, 1'b1);
    chk("mid_rst_hunt_err", 64'(se1), 64'(1'b1));
    chk("mid_rst_hunt_ov",  64'(ov1), 64'(1'b0));
    step(1'b1, 8'h08, 1'b1);
    step(1'b1, 8'h0A, 1'b1);
    step(1'b1, 8'h0B, 1'b1);
    chk("post_rst_valid", 64'(ov1), 64'(1'b1));
    chk("post_rst_data",  64'(od1), 64'(24'h080A0B));
    chk("post_rst_drop",  64'(dc1), 64'(2'd0));

    // Single-byte packets
    do_reset();
    step(1'b1, 8'h08, 1'b1);
    chk("n1_first_valid", 64'(ov2), 64'(1'b1));
    chk("n1_first_data",  64'(od2), 64'(8'h08));
    step(1'b1, 8'h0F, 1'b1);
    chk("n1_b2b_valid", 64'(ov2), 64'(1'b1));
    chk("n1_b2b_data",  64'(od2), 64'(8'h0F));
    step(1'b1, 8'h07, 1'b1);
    chk("n1_rej_valid", 64'(ov2), 64'(1'b0));
    chk("n1_rej_err",   64'(se2), 64'(1'b1));
    step(1'b1, 8'h08, 1'b0);
    step(1'b1, 8'h18, 1'b0);
    chk("n1_drop_held", 64'(od2), 64'(8'h08));
    chk("n1_drop_cnt",  64'(dc2), 64'(8'd1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
